// File: rtl/mult_div_unit_pkg.sv
// ----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the E-stage multiply/divide unit.
//   - op_e    : operation encodings carried on Op
//   - state_e : control FSM states
//   - default multi-cycle latencies for multiply and divide
// ----------------------------------------------------------------------------
package mdu_pkg;

    localparam int MDU_OP_W = 3;

    localparam int MDU_MULT_CYCLES_DEFAULT = 5;
    localparam int MDU_DIV_CYCLES_DEFAULT  = 10;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// ----------------------------------------------------------------------------
// mult_div_unit_if
// Request/result bundle between the execute stage and the multiply/divide
// unit.
//   Start : operation request, sampled at the rising clock edge
//   Op    : operation code (see mdu_pkg::op_e)
//   A, B  : forwarded rs / rt operands
//   Busy  : arithmetic operation in flight
//   Hi,Lo : HI / LO registers
// Modports: master = pipeline side, slave = the unit itself.
// ----------------------------------------------------------------------------
interface mult_div_unit_if;
    import mdu_pkg::*;

    logic                Start;
    logic [MDU_OP_W-1:0] Op;
    logic [31:0]         A;
    logic [31:0]         B;
    logic                Busy;
    logic [31:0]         Hi;
    logic [31:0]         Lo;

    modport master (
        output Start, Op, A, B,
        input  Busy, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Hi, Lo
    );

endinterface

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Multiply/divide unit of the MIPS E stage. Runs mult/multu/div/divu with a
// fixed latency and holds the HI/LO registers read by mfhi/mflo.
//   Clk     : rising-edge clock
//   Reset_n : asynchronous active-low reset (aborts any operation in flight)
//   bus     : mult_div_unit_if.slave (Start, Op, A, B in; Busy, Hi, Lo out)
// Parameters:
//   MULT_CYCLES : edges from an accepted mult/multu to the HI/LO update
//   DIV_CYCLES  : edges from an accepted div/divu to the HI/LO update
// ----------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEFAULT
) (
    input  logic           Clk,
    input  logic           Reset_n,
    mult_div_unit_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_e        state, next_state;
    logic [CW-1:0] count, next_count;
    logic          busy_q, next_busy;
    logic [31:0]   hi_q, next_hi;
    logic [31:0]   lo_q, next_lo;
    logic [31:0]   pend_hi, next_pend_hi;
    logic [31:0]   pend_lo, next_pend_lo;
    logic          pend_commit, next_pend_commit;

    logic [63:0]   prod_s, prod_u;
    logic          neg_a, neg_b;
    logic [31:0]   abs_a, abs_b, sdiv_b, udiv_b;
    logic [31:0]   mag_q, mag_r, sq, sr, uq, ur;

    // Arithmetic on the live operands. Only the accepting edge uses these
    // results, they are latched into pend_hi/pend_lo there.
    // The low 64 bits of a 64x64 product are the same whatever the
    // signedness, so sign- or zero-extending the operands is all that
    // separates mult from multu.
    // Signed divide is done on magnitudes: the quotient is negated when the
    // operand signs differ and the remainder follows the dividend's sign.
    // 0x80000000 has magnitude 0x80000000 as an unsigned value, which gives
    // the wrapped quotient 0x80000000 for 0x80000000 / -1 without special
    // casing. A zero divisor is replaced by 1 only to keep the dividers
    // X-free; that result is never committed.
    always_comb begin
        prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
        prod_u = {32'b0, bus.A} * {32'b0, bus.B};

        neg_a  = bus.A[31];
        neg_b  = bus.B[31];
        abs_a  = neg_a ? -bus.A : bus.A;
        abs_b  = neg_b ? -bus.B : bus.B;
        sdiv_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        udiv_b = (bus.B == 32'd0) ? 32'd1 : bus.B;

        mag_q  = abs_a / sdiv_b;
        mag_r  = abs_a % sdiv_b;
        sq     = (neg_a ^ neg_b) ? -mag_q : mag_q;
        sr     = neg_a ? -mag_r : mag_r;

        uq     = bus.A / udiv_b;
        ur     = bus.A % udiv_b;
    end

    // Control FSM next-state and register update logic. Requests arriving
    // while RUN are dropped; the hazard unit is expected to stall them.
    always_comb begin
        next_state       = state;
        next_count       = count;
        next_busy        = busy_q;
        next_hi          = hi_q;
        next_lo          = lo_q;
        next_pend_hi     = pend_hi;
        next_pend_lo     = pend_lo;
        next_pend_commit = pend_commit;

        unique case (state)
            IDLE: begin
                if (bus.Start) begin
                    case (bus.Op)
                        MDU_MULT: begin
                            next_pend_hi     = prod_s[63:32];
                            next_pend_lo     = prod_s[31:0];
                            next_pend_commit = 1'b1;
                            next_count       = MULT_LOAD;
                            next_busy        = 1'b1;
                            next_state       = RUN;
                        end
                        MDU_MULTU: begin
                            next_pend_hi     = prod_u[63:32];
                            next_pend_lo     = prod_u[31:0];
                            next_pend_commit = 1'b1;
                            next_count       = MULT_LOAD;
                            next_busy        = 1'b1;
                            next_state       = RUN;
                        end
                        MDU_DIV: begin
                            next_pend_hi     = sr;
                            next_pend_lo     = sq;
                            next_pend_commit = (bus.B != 32'd0);
                            next_count       = DIV_LOAD;
                            next_busy        = 1'b1;
                            next_state       = RUN;
                        end
                        MDU_DIVU: begin
                            next_pend_hi     = ur;
                            next_pend_lo     = uq;
                            next_pend_commit = (bus.B != 32'd0);
                            next_count       = DIV_LOAD;
                            next_busy        = 1'b1;
                            next_state       = RUN;
                        end
                        MDU_MTHI: next_hi = bus.A;
                        MDU_MTLO: next_lo = bus.A;
                        default:  ;
                    endcase
                end
            end
            RUN: begin
                next_count = count - ONE;
                if (count == ONE) begin
                    next_state = IDLE;
                    next_busy  = 1'b0;
                    if (pend_commit) begin
                        next_hi = pend_hi;
                        next_lo = pend_lo;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State and output registers; reset abandons any pending result.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            count       <= '0;
            busy_q      <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            pend_hi     <= 32'd0;
            pend_lo     <= 32'd0;
            pend_commit <= 1'b0;
        end else begin
            state       <= next_state;
            count       <= next_count;
            busy_q      <= next_busy;
            hi_q        <= next_hi;
            lo_q        <= next_lo;
            pend_hi     <= next_pend_hi;
            pend_lo     <= next_pend_lo;
            pend_commit <= next_pend_commit;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: a table of directed vectors, hand
// sequences for reset, ignored requests and back-to-back issue, then random
// operations compared against a 64-bit arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic Clk;
    logic Reset_n;

    mult_div_unit_if bus ();

    mult_div_unit #(
        .MULT_CYCLES (MULT_LAT),
        .DIV_CYCLES  (DIV_LAT)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs [13];

    logic [31:0] ref_hi;
    logic [31:0] ref_lo;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case the stimulus process ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Present one request for a single edge, then scramble the operands so a
    // design that samples them late is caught. Returns 1 time unit after E0.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        step();
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    // Issue an operation, check HI/LO hold their old values while busy and
    // count how many cycles Busy stays high.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                         input string tag, output int lat);
        applyStimulus(op, a, b);
        lat = 0;
        while (bus.Busy === 1'b1 && lat < 100) begin
            if (lat == 0) begin
                checkOutput({tag, " hold hi"}, bus.Hi, prev_hi);
                checkOutput({tag, " hold lo"}, bus.Lo, prev_lo);
            end
            lat++;
            step();
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the operation's meaning.
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           inout logic [31:0] hi, inout logic [31:0] lo, output int lat);
        longint          sp, sa, sb, sq, sr;
        longint unsigned up, ua, ub, uq, ur;
        lat = 0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; lat = MULT_LAT; end
            3'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; lat = MULT_LAT; end
            3'd2: begin
                lat = DIV_LAT;
                if (b != 32'd0) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    hi = sr[31:0];
                    lo = sq[31:0];
                end
            end
            3'd3: begin
                lat = DIV_LAT;
                if (b != 32'd0) begin
                    uq = ua / ub;
                    ur = ua % ub;
                    hi = ur[31:0];
                    lo = uq[31:0];
                end
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endtask

    initial begin
        int lat;
        int edges;
        logic [31:0] ph, pl;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          elat;

        vecs[0]  = '{MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, MULT_LAT};
        vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, MULT_LAT};
        vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
        vecs[3]  = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, DIV_LAT};
        vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT};
        vecs[5]  = '{MDU_MTHI,  32'h00000005, 32'h00000000, 32'h00000005, 32'h80000000, 0};
        vecs[6]  = '{MDU_MTLO,  32'h00000006, 32'h00000000, 32'h00000005, 32'h00000006, 0};
        vecs[7]  = '{MDU_DIV,   32'h00000009, 32'h00000000, 32'h00000005, 32'h00000006, DIV_LAT};
        vecs[8]  = '{MDU_DIVU,  32'h00000009, 32'h00000000, 32'h00000005, 32'h00000006, DIV_LAT};
        vecs[9]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULT_LAT};
        vecs[10] = '{3'd6,      32'h0000007B, 32'h00000001, 32'h40000000, 32'h00000000, 0};
        vecs[11] = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT};
        vecs[12] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MULT_LAT};

        Reset_n   = 1'b0;
        bus.Start = 1'b0;
        bus.Op    = 3'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (2) step();

        checkOutput("reset busy", {31'b0, bus.Busy}, 32'd0);
        checkOutput("reset hi", bus.Hi, 32'd0);
        checkOutput("reset lo", bus.Lo, 32'd0);
        Reset_n = 1'b1;
        step();

        // Directed vectors, issued back to back.
        ph = 32'd0;
        pl = 32'd0;
        for (int i = 0; i < 13; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, ph, pl, $sformatf("vec%0d", i), lat);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            checkOutput($sformatf("vec%0d hi", i), bus.Hi, vecs[i].hi);
            checkOutput($sformatf("vec%0d lo", i), bus.Lo, vecs[i].lo);
            ph = vecs[i].hi;
            pl = vecs[i].lo;
        end

        // Reset two cycles into a multiply: immediate clear, no late commit.
        runOp(MDU_MTHI, 32'h11, 32'h0, ph, pl, "pre mthi", lat);
        runOp(MDU_MTLO, 32'h22, 32'h0, 32'h11, pl, "pre mtlo", lat);
        checkOutput("pre hi", bus.Hi, 32'h11);
        checkOutput("pre lo", bus.Lo, 32'h22);
        applyStimulus(MDU_MULT, 32'd3, 32'd4);
        step();
        step();
        Reset_n = 1'b0;
        #1;
        checkOutput("midrun reset busy", {31'b0, bus.Busy}, 32'd0);
        checkOutput("midrun reset hi", bus.Hi, 32'd0);
        checkOutput("midrun reset lo", bus.Lo, 32'd0);
        step();
        Reset_n = 1'b1;
        repeat (12) step();
        checkOutput("post reset busy", {31'b0, bus.Busy}, 32'd0);
        checkOutput("post reset hi", bus.Hi, 32'd0);
        checkOutput("post reset lo", bus.Lo, 32'd0);

        // Requests while busy are dropped, including mtlo.
        applyStimulus(MDU_MULT, 32'd2, 32'd3);
        bus.Start = 1'b1;
        bus.Op    = MDU_MTLO;
        bus.A     = 32'hAA;
        step();
        bus.Op    = MDU_DIVU;
        bus.A     = 32'd8;
        bus.B     = 32'd2;
        step();
        bus.Start = 1'b0;
        edges = 2;
        while (bus.Busy === 1'b1 && edges < 50) begin
            edges++;
            step();
        end
        checkOutput("busy fall edge", 32'(edges), 32'd5);
        checkOutput("ignored hi", bus.Hi, 32'd0);
        checkOutput("ignored lo", bus.Lo, 32'd6);

        // Back-to-back: divu accepted on the first Busy=0 edge.
        runOp(MDU_MULT, 32'd2, 32'd3, 32'd0, 32'd6, "b2b mult", lat);
        checkOutput("b2b mult latency", 32'(lat), 32'(MULT_LAT));
        checkOutput("b2b gap lo", bus.Lo, 32'd6);
        runOp(MDU_DIVU, 32'd100, 32'd7, 32'd0, 32'd6, "b2b divu", lat);
        checkOutput("b2b divu latency", 32'(lat), 32'(DIV_LAT));
        checkOutput("b2b divu hi", bus.Hi, 32'd2);
        checkOutput("b2b divu lo", bus.Lo, 32'd14);

        // Random operations against the reference model.
        ref_hi = 32'd2;
        ref_lo = 32'd14;
        for (int n = 0; n < 200; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 15))
                0, 1: rb = 32'd0;
                2:    begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                3:    rb = 32'($urandom_range(1, 9));
                4:    ra = 32'($urandom_range(0, 20));
                default: ;
            endcase
            ph = ref_hi;
            pl = ref_lo;
            modelOp(rop, ra, rb, ref_hi, ref_lo, elat);
            runOp(rop, ra, rb, ph, pl, "rnd", lat);
            checkOutput($sformatf("rnd%0d op%0d latency", n, rop), 32'(lat), 32'(elat));
            checkOutput($sformatf("rnd%0d op%0d hi", n, rop), bus.Hi, ref_hi);
            checkOutput($sformatf("rnd%0d op%0d lo", n, rop), bus.Lo, ref_lo);
            repeat ($urandom_range(0, 2)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit in the E stage of the pipelined MIPS core. It takes the forwarded register-file operands that the decode/execute path reads from the GRF and runs mult/multu/div/divu over a fixed multi-cycle latency. It holds the HI/LO registers, which mfhi/mflo return to the GRF write-back path. Its Busy output drives the hazard unit's stall decision.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update (≥1)
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update (≥1)

Ports:
- Clk  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  operation request; sampled at rising edge
- Op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7 reserved
- A  in  32  rs operand (forwarded GRF read data)
- B  in  32  rt operand (forwarded GRF read data)
- Busy  out  1  arithmetic operation in flight
- Hi  out  32  HI register, direct register output
- Lo  out  32  LO register, direct register output

## Operation
- Reset (async, Reset_n=0): Hi=0, Lo=0, Busy=0, cycle counter=0, pending result=0. This takes effect immediately and aborts any in-flight operation with no commit.
- States: IDLE, RUN.
- IDLE with Start=1, Op 0–3:
  - Compute the result from A and B at this edge and latch it into pending HI/LO.
  - Load counter with MULT_CYCLES or DIV_CYCLES, set Busy=1, go to RUN.
  - Later changes on A/B have no effect.
- IDLE with Start=1, Op 4: Hi←A at this edge. Op 5: Lo←A at this edge. No Busy, stays IDLE.
- IDLE with Start=1, Op 6/7: ignored, no state change.
- RUN: counter decrements each edge. At the edge where counter goes 1→0: Hi/Lo←pending, Busy←0, go to IDLE.
- Start while Busy=1 (any Op, including mthi/mtlo): ignored. The hazard unit must stall on (Start & Op∈{0..3}) | Busy so this never occurs legally.
- mult: signed 32×32→64; Hi=product[63:32], Lo=product[31:0]. multu: the same, unsigned.
- div: signed; Lo=quotient truncated toward zero; Hi=remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- divu: unsigned; Lo=quotient, Hi=remainder.
- Divide by zero (B=0, div or divu): runs the full DIV_CYCLES with Busy, then Hi/Lo keep their prior values (no commit).

## Timing
- Start accepted at edge E0 → Busy=1 from E0 through edge E0+N (N=MULT_CYCLES or DIV_CYCLES).
  - Busy is high for exactly N cycles.
  - Hi/Lo show the new values after edge E0+N.
  - The same edge clears Busy.
- A new operation can be accepted at edge E0+N+1, i.e. the first edge with Busy=0. No bubble beyond that.
- mthi/mtlo: Hi/Lo change after the accepting edge; 1-cycle latency.
- Hi/Lo are stable and readable (mfhi/mflo) while Busy=1 and show the pre-operation values.
- Busy and Hi/Lo are registered outputs; no combinational path from Start/A/B.

## Structure
- Shared package mdu_pkg:
  - Op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - State encoding: IDLE, RUN.
  - Default latency constants.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- No sub-module required. Arithmetic is inline behavioural (* and / and %), with explicit sign handling for div.
- Target size: 120–200 lines.

## Test plan
- Reset mid-RUN:
  - Setup: mthi 0x11, mtlo 0x22; then start mult A=3, B=4; deassert Reset_n two cycles later.
  - Required: Hi=Lo=0 and Busy=0 immediately. After release, no commit ever happens (Hi/Lo stay 0).
- mult, A=0xFFFFFFFF (−1), B=2:
  - Busy high exactly 5 cycles.
  - Then Hi=0xFFFFFFFF, Lo=0xFFFFFFFE.
  - Same operands with multu give Hi=0x00000001, Lo=0xFFFFFFFE.
- div, A=0xFFFFFFF9 (−7), B=2:
  - Busy high exactly 10 cycles.
  - Then Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1).
  - divu with A=7, B=2 gives Lo=3, Hi=1.
- Overflow and divide by zero:
  - div 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
  - Then mthi 0x5, mtlo 0x6, then div 9/0 → Busy 10 cycles, and Hi=0x5, Lo=0x6 remain.
- Start during Busy:
  - Issue mult 2×3, then mtlo 0xAA and divu 8/2 while Busy.
  - Required: both ignored; final Hi=0, Lo=6. Busy falls on the 5th edge after the start edge.
- Back-to-back:
  - mult 2×3 accepted, then divu 100/7 accepted on the first cycle Busy=0.
  - Required: Lo=6 visible for exactly that 1 cycle gap edge, then Busy for 10 cycles, then Lo=14, Hi=2.
